tile_accum_ctrl: RTL

Sequencer for the tile-sum accumulator in the LSTM matrix-vector path. Each output element is built from a configurable number of tile partial sums. This block:
- clears the accumulator;
- accepts tile sums over a valid/ready handshake and steers them into the accumulator;
- counts tiles and captures the final sum into a held result register;
- presents that result over a second valid/ready handshake.

It sits between the tile MAC array (upstream) and the activation stage (downstream), and drives the external accumulator's clear, valid and data inputs.

---
 rtl/tile_accum_pkg.sv | 18 +
 rtl/tile_accum_ctrl_acc.sv | 31 +++
 rtl/tile_accum_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/tile_accum_pkg.sv
// Shared definitions for the tile-sum accumulator sequencer.
//   state_e : controller states
//   cnt_w() : width of a tile counter able to hold 0..max_tiles
package tile_accum_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_ACCUM   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  function automatic int cnt_w(input int max_tiles);
    return $clog2(max_tiles + 1);
  endfunction

endpackage

// File: rtl/tile_accum_ctrl_acc.sv
// Tile-sum accumulator that sits beside tile_accum_ctrl in the parent.
// It is deliberately not reset by the controller's reset.
// Ports:
//   clk   : clock
//   clear : synchronous clear (wins over add)
//   valid : add-enable
//   tile  : addend
//   sum   : running sum, wraps modulo 2^DATA_WIDTH
module tile_accum_ctrl_acc #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] tile,
  output logic [DATA_WIDTH-1:0] sum
);

  logic [DATA_WIDTH-1:0] sum_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      sum_q <= '0;
    end else if (valid) begin
      sum_q <= sum_q + tile;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/tile_accum_ctrl.sv
// Sequencer for the tile-sum accumulator: clears the external accumulator,
// steers a configurable number of tile sums into it, captures the final sum
// into a held result register and presents it over a valid/ready handshake.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   start, cfg_tiles         : begin an element of cfg_tiles tiles (IDLE only)
//   abort                    : synchronous cancel from any non-IDLE state
//   tile_valid/ready/sum     : upstream tile-sum handshake
//   acc_clear/valid/tile     : drive of the external accumulator
//   acc_sum                  : accumulator current value
//   out_valid/ready/sum      : downstream result handshake
//   busy, tiles_done         : status
//   cfg_err                  : one-cycle pulse on a rejected start
module tile_accum_ctrl
  import tile_accum_pkg::*;
#(
  parameter  int DATA_WIDTH = 64,
  parameter  int MAX_TILES  = 16,
  localparam int CNT_W      = cnt_w(MAX_TILES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_W-1:0]      cfg_tiles,
  input  logic                  abort,
  input  logic                  tile_valid,
  output logic                  tile_ready,
  input  logic [DATA_WIDTH-1:0] tile_sum,
  output logic                  acc_clear,
  output logic                  acc_valid,
  output logic [DATA_WIDTH-1:0] acc_tile,
  input  logic [DATA_WIDTH-1:0] acc_sum,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_sum,
  output logic                  busy,
  output logic [CNT_W-1:0]      tiles_done,
  output logic                  cfg_err
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TILES);

  state_e                state_q;
  logic [CNT_W-1:0]      cfg_q;
  logic [CNT_W-1:0]      tiles_done_q;
  logic [CNT_W-1:0]      tiles_done_d;
  logic [DATA_WIDTH-1:0] out_sum_q;
  logic                  out_valid_q;
  logic                  cfg_err_q;

  logic cfg_legal;
  logic abort_act;
  logic accept;
  logic last_tile;

  assign cfg_legal    = (cfg_tiles != '0) && (cfg_tiles <= MAX_CNT);
  assign abort_act    = abort && (state_q != ST_IDLE);
  // An aborting cycle must not consume a tile, so ready drops with abort.
  assign tile_ready   = (state_q == ST_ACCUM) && !abort;
  assign accept       = tile_valid && tile_ready;
  assign tiles_done_d = tiles_done_q + CNT_W'(1);
  assign last_tile    = accept && (tiles_done_d == cfg_q);

  assign acc_clear  = (state_q == ST_CLEAR) || abort_act;
  assign acc_valid  = accept;
  assign acc_tile   = tile_sum;
  assign busy       = (state_q != ST_IDLE);
  assign out_valid  = out_valid_q;
  assign out_sum    = out_sum_q;
  assign tiles_done = tiles_done_q;
  assign cfg_err    = cfg_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cfg_q        <= '0;
      tiles_done_q <= '0;
      out_sum_q    <= '0;
      out_valid_q  <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      cfg_err_q <= 1'b0;
      if (abort_act) begin
        state_q      <= ST_IDLE;
        out_valid_q  <= 1'b0;
        tiles_done_q <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              if (cfg_legal) begin
                cfg_q        <= cfg_tiles;
                tiles_done_q <= '0;
                state_q      <= ST_CLEAR;
              end else begin
                cfg_err_q <= 1'b1;
              end
            end
          end
          ST_CLEAR: begin
            state_q <= ST_ACCUM;
          end
          ST_ACCUM: begin
            if (accept) begin
              tiles_done_q <= tiles_done_d;
            end
            if (last_tile) begin
              state_q <= ST_CAPTURE;
            end
          end
          // The last add lands in the accumulator at the edge entering
          // CAPTURE, so acc_sum is final here.
          ST_CAPTURE: begin
            out_sum_q   <= acc_sum;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
          ST_DONE: begin
            if (out_ready) begin
              out_valid_q <= 1'b0;
              state_q     <= ST_IDLE;
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
